// File: rtl/waveform_analyzer_pkg.sv
// Shared types and default sizing for the waveform analyzer.
package waveform_analyzer_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_LEARN_LEN = 256;
    localparam int DEF_HYST      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEARN,
        ST_CALC,
        ST_ARM,
        ST_WAIT_RISE,
        ST_FALL,
        ST_RISE,
        ST_DONE
    } wa_state_e;

endpackage

// File: rtl/waveform_analyzer_if.sv
// Sample stream in, measurement results out.
interface waveform_analyzer_if
    import waveform_analyzer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              start;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              busy;
    logic              meas_valid;
    logic [CNT_W-1:0]  period;
    logic [DATA_W-1:0] vmin;
    logic [DATA_W-1:0] vmax;
    logic              flat;
    logic              timeout;

    // Sample source / register side
    modport master (
        output start, sample_valid, sample,
        input  busy, meas_valid, period, vmin, vmax, flat, timeout
    );

    // Analyzer side
    modport slave (
        input  start, sample_valid, sample,
        output busy, meas_valid, period, vmin, vmax, flat, timeout
    );

endinterface

// File: rtl/wa_threshold_calc.sv
// Midpoint threshold with saturating hysteresis band, plus flat detection.
module wa_threshold_calc
    import waveform_analyzer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int HYST   = DEF_HYST
) (
    input  logic [DATA_W-1:0] vmin,
    input  logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              flat
);

    localparam logic [DATA_W:0] HYST_X  = (DATA_W+1)'(HYST);
    localparam logic [DATA_W:0] HYST2_X = (DATA_W+1)'(2 * HYST);

    logic [DATA_W-1:0] mid;

    // a - HYST, clamped at 0
    function automatic logic [DATA_W-1:0] sat_sub_hyst(input logic [DATA_W-1:0] a);
        logic [DATA_W:0] ax;
        ax = {1'b0, a};
        if (ax < HYST_X) return '0;
        return DATA_W'(ax - HYST_X);
    endfunction

    // a + HYST, clamped at full scale
    function automatic logic [DATA_W-1:0] sat_add_hyst(input logic [DATA_W-1:0] a);
        logic [DATA_W:0] s;
        s = {1'b0, a} + HYST_X;
        if (s[DATA_W]) return '1;
        return s[DATA_W-1:0];
    endfunction

    // Sum carried one bit wider so the average never wraps
    assign mid  = DATA_W'(({1'b0, vmin} + {1'b0, vmax}) >> 1);
    assign lo   = sat_sub_hyst(mid);
    assign hi   = sat_add_hyst(mid);
    assign flat = ({1'b0, vmax} - {1'b0, vmin}) < HYST2_X;

endmodule

// File: rtl/waveform_analyzer.sv
// Learns min/max of a sample stream, then measures rising-crossing period.
module waveform_analyzer
    import waveform_analyzer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LEARN_LEN = DEF_LEARN_LEN,
    parameter int HYST      = DEF_HYST
) (
    input logic                clk,
    input logic                rst,
    waveform_analyzer_if.slave bus
);

    localparam int                LCNT_W     = $clog2(LEARN_LEN + 1);
    localparam logic [LCNT_W-1:0] LEARN_LAST = LCNT_W'(LEARN_LEN - 1);
    // Count value whose next sample makes 2^CNT_W-1 samples
    localparam logic [CNT_W-1:0]  TMO_LAST   = ~(CNT_W'(1));

    wa_state_e         state, state_nxt;
    logic [LCNT_W-1:0] learn_cnt;
    logic [DATA_W-1:0] minv, maxv;
    logic [DATA_W-1:0] lo, hi;
    logic              is_flat;
    logic [CNT_W-1:0]  tcnt, pcnt;
    logic [CNT_W-1:0]  period_r;
    logic [DATA_W-1:0] vmin_r, vmax_r;
    logic              flat_r, timeout_r;
    logic              sv, at_lo, at_hi, tmo_hit;
    logic              fin_flat, fin_meas, fin_tmo;

    wa_threshold_calc #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_thr (
        .vmin (minv),
        .vmax (maxv),
        .lo   (lo),
        .hi   (hi),
        .flat (is_flat)
    );

    // Equality with a threshold counts as crossed
    assign sv      = bus.sample_valid;
    assign at_lo   = bus.sample <= lo;
    assign at_hi   = bus.sample >= hi;
    assign tmo_hit = sv && (tcnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and result-load strobes; timeout beats intermediate crossings, a completing rise beats timeout
    always_comb begin
        state_nxt = state;
        fin_flat  = 1'b0;
        fin_meas  = 1'b0;
        fin_tmo   = 1'b0;
        case (state)
            ST_IDLE:      if (bus.start) state_nxt = ST_LEARN;
            ST_LEARN:     if (sv && learn_cnt == LEARN_LAST) state_nxt = ST_CALC;
            ST_CALC: begin
                if (is_flat) begin
                    state_nxt = ST_DONE;
                    fin_flat  = 1'b1;
                end else begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    fin_tmo   = 1'b1;
                end else if (sv && at_lo) begin
                    state_nxt = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    fin_tmo   = 1'b1;
                end else if (sv && at_hi) begin
                    state_nxt = ST_FALL;
                end
            end
            ST_FALL: begin
                if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    fin_tmo   = 1'b1;
                end else if (sv && at_lo) begin
                    state_nxt = ST_RISE;
                end
            end
            ST_RISE: begin
                if (sv && at_hi) begin
                    state_nxt = ST_DONE;
                    fin_meas  = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    fin_tmo   = 1'b1;
                end
            end
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Learning window: running min/max seeded by the first valid sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            learn_cnt <= '0;
            minv      <= '0;
            maxv      <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            learn_cnt <= '0;
        end else if (state == ST_LEARN && sv) begin
            learn_cnt <= learn_cnt + 1'b1;
            if (learn_cnt == '0) begin
                minv <= bus.sample;
                maxv <= bus.sample;
            end else begin
                if (bus.sample < minv) minv <= bus.sample;
                if (bus.sample > maxv) maxv <= bus.sample;
            end
        end
    end

    // Timeout and period counters, advanced only by valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            pcnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        tcnt <= '0;
                        pcnt <= '0;
                    end
                end
                ST_CALC: begin
                    tcnt <= '0;
                    pcnt <= '0;
                end
                ST_ARM: begin
                    if (sv) tcnt <= tcnt + 1'b1;
                end
                ST_WAIT_RISE: begin
                    if (sv) begin
                        tcnt <= tcnt + 1'b1;
                        if (at_hi) pcnt <= CNT_W'(1);
                    end
                end
                ST_FALL: begin
                    if (sv) begin
                        tcnt <= tcnt + 1'b1;
                        pcnt <= pcnt + 1'b1;
                    end
                end
                ST_RISE: begin
                    if (sv) begin
                        tcnt <= tcnt + 1'b1;
                        if (!at_hi) pcnt <= pcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers, loaded on entry to DONE and held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_r  <= '0;
            vmin_r    <= '0;
            vmax_r    <= '0;
            flat_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else if (fin_flat || fin_tmo || fin_meas) begin
            period_r  <= fin_meas ? pcnt : '0;
            vmin_r    <= minv;
            vmax_r    <= maxv;
            flat_r    <= fin_flat;
            timeout_r <= fin_tmo;
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.meas_valid = (state == ST_DONE);
    assign bus.period     = period_r;
    assign bus.vmin       = vmin_r;
    assign bus.vmax       = vmax_r;
    assign bus.flat       = flat_r;
    assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench: measurements push expected results, a monitor pops on meas_valid.
module tb_waveform_analyzer;

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  vmin;
        logic [7:0]  vmax;
        logic        flat;
        logic        timeout;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n_valid  = 0;
    res_t exp_q[$];
    res_t mon_e;
    string cur_name = "init";

    always #5 clk = ~clk;

    waveform_analyzer_if #(.DATA_W(8), .CNT_W(16)) bus ();

    waveform_analyzer #(
        .DATA_W    (8),
        .CNT_W     (16),
        .LEARN_LEN (256),
        .HYST      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every result strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && bus.meas_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_meas_valid actual=period %0d required=no strobe", bus.period);
            end else begin
                mon_e = exp_q.pop_front();
                chk({cur_name, "_period"},  int'(bus.period),  int'(mon_e.period));
                chk({cur_name, "_vmin"},    int'(bus.vmin),    int'(mon_e.vmin));
                chk({cur_name, "_vmax"},    int'(bus.vmax),    int'(mon_e.vmax));
                chk({cur_name, "_flat"},    int'(bus.flat),    int'(mon_e.flat));
                chk({cur_name, "_timeout"}, int'(bus.timeout), int'(mon_e.timeout));
            end
        end
    end

    // kind 0 square, 1 triangle 0..255..1, 2 constant, 3 square then held at a
    function automatic logic [7:0] wave(input int kind, input int i, input int h,
                                        input int a, input int b);
        int p;
        case (kind)
            0: return 8'(((i / h) % 2) != 0 ? b : a);
            1: begin
                p = i % 510;
                return 8'(p <= 255 ? p : 510 - p);
            end
            2: return 8'(a);
            default: return 8'((i < 256 && ((i / h) % 2) != 0) ? b : a);
        endcase
    endfunction

    task automatic pulse_start(input string name);
        @(posedge clk); #1;
        bus.start        = 1'b1;
        bus.sample_valid = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({name, "_busy_after_start"}, int'(bus.busy), 1);
    endtask

    // Streams samples; idx returns the number of samples presented
    task automatic drive(input int kind, input int h, input int a, input int b,
                         input int gap, input int start_at, input int max_samp,
                         input int target, input int max_cyc,
                         output bit reached, output int idx);
        int cyc;
        bit sent;
        idx = 0; cyc = 0; reached = 1'b0; sent = 1'b0;
        while (cyc < max_cyc && idx < max_samp) begin
            if (target > 0 && n_valid >= target) begin
                reached = 1'b1;
                break;
            end
            bus.sample_valid = ((cyc % gap) == 0);
            bus.sample       = wave(kind, idx, h, a, b);
            bus.start        = 1'b0;
            if (bus.sample_valid) begin
                if (idx == start_at && !sent) begin
                    bus.start = 1'b1;
                    sent      = 1'b1;
                end
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!reached && target > 0 && n_valid >= target) reached = 1'b1;
        bus.sample_valid = 1'b0;
        bus.start        = 1'b0;
    endtask

    task automatic measure(input string name, input int kind, input int h, input int a,
                           input int b, input int gap, input int p, input int vmn,
                           input int vmx, input int fl, input int to,
                           input int start_at, input int exp_idx, input int max_cyc);
        bit   ok;
        int   idx;
        res_t e;
        cur_name  = name;
        e.period  = 16'(p);
        e.vmin    = 8'(vmn);
        e.vmax    = 8'(vmx);
        e.flat    = fl[0];
        e.timeout = to[0];
        exp_q.push_back(e);
        pulse_start(name);
        drive(kind, h, a, b, gap, start_at, 1 << 30, n_valid + 1, max_cyc, ok, idx);
        chk({name, "_done_in_budget"}, int'(ok), 1);
        if (!ok) begin
            exp_q.delete();
        end else begin
            chk({name, "_busy_after_done"}, int'(bus.busy), 0);
            if (exp_idx >= 0) chk({name, "_samples_to_done"}, idx, exp_idx);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int idx;
        int base;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",       int'(bus.busy),       0);
        chk("reset_meas_valid", int'(bus.meas_valid), 0);
        chk("reset_period",     int'(bus.period),     0);
        chk("reset_vmin",       int'(bus.vmin),       0);
        chk("reset_vmax",       int'(bus.vmax),       0);
        chk("reset_flat",       int'(bus.flat),       0);
        chk("reset_timeout",    int'(bus.timeout),    0);
        rst = 1'b0;

        //        name       kind h    a    b    gap per  mn   mx   fl to st_at idx    budget
        measure("square",    0, 128, 0,   255, 1, 256, 0,   255, 0, 0, -1,  642,  5000);
        measure("triangle",  1, 1,   0,   0,   3, 510, 0,   255, 0, 0, -1,  1156, 6000);
        measure("constant",  2, 1,   100, 0,   1, 0,   100, 100, 1, 0, -1,  258,  2000);
        measure("low_sq",    0, 64,  0,   20,  1, 128, 0,   20,  0, 0, -1,  450,  3000);
        measure("flat_hi",   0, 64,  240, 255, 1, 0,   240, 255, 1, 0, -1,  258,  2000);
        measure("restart",   0, 128, 0,   255, 1, 256, 0,   255, 0, 0, 100, 642,  5000);
        measure("restart2",  0, 128, 0,   255, 1, 256, 0,   255, 0, 0, 400, 642,  5000);

        // Abort in FALL: outputs clear asynchronously and no strobe follows
        cur_name = "rst_mid";
        pulse_start("rst_mid");
        drive(0, 128, 0, 255, 1, -1, 450, 0, 5000, ok, idx);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy",       int'(bus.busy),       0);
        chk("rst_mid_meas_valid", int'(bus.meas_valid), 0);
        chk("rst_mid_period",     int'(bus.period),     0);
        chk("rst_mid_vmin",       int'(bus.vmin),       0);
        chk("rst_mid_vmax",       int'(bus.vmax),       0);
        chk("rst_mid_flat",       int'(bus.flat),       0);
        chk("rst_mid_timeout",    int'(bus.timeout),    0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = n_valid;
        drive(0, 128, 0, 255, 1, -1, 700, 0, 1000, ok, idx);
        chk("rst_mid_no_strobe", n_valid, base);
        chk("rst_mid_idle",      int'(bus.busy), 0);

        measure("fresh",     0, 128, 0,   255, 1, 256, 0,   255, 0, 0, -1,  642,  5000);
        measure("timeout",   3, 128, 0,   255, 1, 0,   0,   255, 0, 1, -1,  65793, 70000);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("strobe_count",  n_valid, 9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/waveform_analyzer.md
Name: waveform_analyzer

Overview:
Receive-side counterpart of the team's 8-bit waveform generator. It consumes a qualified 8-bit sample stream, learns min/max over a fixed window and derives a midpoint threshold with hysteresis. It then measures the period in samples between two rising threshold crossings and reports period, min and max with a one-cycle result strobe. It sits in the lab bench between a generator/ADC sample source and the display/register logic.

Parameters:
DATA_W, 8, sample width
CNT_W, 16, width of period and timeout counters
LEARN_LEN, 256, samples observed in the min/max learning window
HYST, 8, hysteresis half-width around the midpoint (sample units)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a measurement
sample_valid  in  1  sample qualifier; only cycles with sample_valid=1 advance the analyzer
sample  in  DATA_W  unsigned sample
busy  out  1  high from accepted start until meas_valid
meas_valid  out  1  one-cycle result strobe
period  out  CNT_W  period in samples; 0 when flat or timeout
vmin  out  DATA_W  minimum seen in learning window
vmax  out  DATA_W  maximum seen in learning window
flat  out  1  max-min < 2*HYST; no period measured
timeout  out  1  no crossing within 2^CNT_W-1 samples

Behaviour:
- Reset: FSM=IDLE; busy=0, meas_valid=0, period=0, vmin=0, vmax=0, flat=0, timeout=0. Reset mid-operation aborts immediately, with no meas_valid.
- Result outputs (period, vmin, vmax, flat, timeout) are registered and hold until the next DONE. meas_valid is high only in the DONE cycle.
- State IDLE: start=1 -> LEARN, busy=1, clear the internal counters. start is ignored in every other state.
- State LEARN: each valid sample updates the running min/max (initialised from the first valid sample) and increments the learn count. After the LEARN_LEN-th valid sample -> CALC.
- State CALC (1 cycle, no sample consumed):
  - mid = (min+max)>>1, computed on a DATA_W+1 sum.
  - lo = mid-HYST, saturating at 0. hi = mid+HYST, saturating at 2^DATA_W-1.
  - If max-min < 2*HYST: flat=1 -> DONE. Otherwise -> ARM.
- State ARM: wait for a valid sample <= lo, then -> WAIT_RISE.
- State WAIT_RISE: wait for a valid sample >= hi. On it, period count=1 and -> FALL.
- State FALL: count each valid sample. On a sample <= lo -> RISE.
- State RISE: count each valid sample. On a sample >= hi -> DONE with period = count, excluding the crossing sample. Period therefore equals samples from crossing to crossing.
- Timeout: a shared sample counter runs in ARM, WAIT_RISE, FALL and RISE and is reset on entry to ARM. When it reaches 2^CNT_W-1 -> DONE with timeout=1, period=0.
- State DONE (1 cycle): meas_valid=1, busy=0 on the following cycle -> IDLE. start arriving in the DONE cycle is ignored.
- Gaps in sample_valid stall all counters. The period is in samples, not clocks.
- A sample exactly equal to lo or hi counts as crossed.
- Learn count and window are independent of the timeout counter.

Decomposition:
- Shared package: FSM state enum (IDLE, LEARN, CALC, ARM, WAIT_RISE, FALL, RISE, DONE) and default constants for DATA_W, CNT_W, LEARN_LEN, HYST.
- One natural sub-module: wa_threshold_calc, purely combinational, taking min/max/HYST and producing mid/lo/hi/flat with saturation. The top level keeps the FSM, counters and result registers.

Test Plan:
- Square wave: 128 samples of 0 then 128 of 255, repeated, sample_valid=1 always, start pulse -> vmin=0, vmax=255, period=256, flat=0, timeout=0, one meas_valid.
- Triangle 0..255..1 (period 510), sample_valid asserted every 3rd clock -> period=510, vmin=0, vmax=255, result unaffected by gaps.
- Constant sample=100 -> after 256 samples plus CALC, meas_valid with flat=1, period=0, vmin=vmax=100.
- Square 0/255 for 256 samples, then held at 0 -> timeout=1, period=0 after 65535 valid samples in ARM/WAIT/FALL/RISE.
- Low-range square (lo/hi saturation): square 0/20 with HYST=8 -> mid=10, lo=2, hi=18, period measured correctly. Square 240/255 gives flat=1 (15 < 16).
- Boundary and reset cases:
  - Second start while busy is ignored, so only one meas_valid.
  - rst asserted during FALL -> all outputs return to 0 asynchronously, and no meas_valid appears.
  - A fresh start after reset measures normally.
